// File: rtl/cpr_stream_packer.sv
// cpr_stream_packer: serialises compressed blocks (one tag halfword plus
// popcount(tag) payload halfwords) into a gap-free stream of full data words.
// Each block is appended to a two-word halfword buffer. The low word is
// presented on the output once it is full, or during a flush once any data
// is buffered. In that case, halfwords above the fill count read as zero.
//
// Optional build macro: PACKER_BLKCNT_EN adds a 32-bit accepted-block counter
// output (blkCount). The counter clears on the flushDone cycle.
module cpr_stream_packer #(
  parameter int HW_W   = 16,
  parameter int NUM_HW = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [HW_W*NUM_HW-1:0]   cprDataIn,
  input  logic [NUM_HW-1:0]        tagIn,
  input  logic                     flush,
  output logic [HW_W*NUM_HW-1:0]   dataOut,
  output logic [$clog2(NUM_HW+1)-1:0] outLen,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     flushDone
`ifdef PACKER_BLKCNT_EN
  ,
  output logic [31:0]              blkCount
`endif
);

  localparam int DATA_W = HW_W * NUM_HW;
  localparam int BUF_HW = 2 * NUM_HW;
  localparam int BUF_W  = 2 * DATA_W;
  localparam int CNT_W  = $clog2(BUF_HW + 1);
  localparam int LEN_W  = $clog2(NUM_HW + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_HW);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BUF_W-1:0]   buf_q,   buf_d;

  logic [CNT_W-1:0]   pop_n;
  logic               accept;
  logic               out_fire;
  logic [BUF_HW-1:0]  len_mask;
  logic [BUF_HW-1:0]  hw_mask;
  logic [BUF_W-1:0]   data_mask;
  logic [BUF_W-1:0]   blk_ext;
  logic [BUF_W-1:0]   blk_ins;

  // Payload length: number of set bits in the tag.
  always_comb begin
    pop_n = '0;
    for (int i = 0; i < NUM_HW; i++) begin
      pop_n = pop_n + CNT_W'(tagIn[i]);
    end
  end

  // Handshake qualifiers and status outputs, all derived from registered state.
  always_comb begin
    inReady   = (state_q == ST_ACCUM) && (cnt_q < CNT_FULL);
    outValid  = (cnt_q >= CNT_FULL) || ((state_q == ST_FLUSH) && (cnt_q != '0));
    flushDone = (state_q == ST_FLUSH) && (cnt_q == '0);
    // A flush request takes priority over a block offered in the same cycle.
    accept    = inValid && inReady && !flush;
    out_fire  = outValid && outReady;
    dataOut   = buf_q[DATA_W-1:0];
    outLen    = (cnt_q >= CNT_FULL) ? LEN_W'(NUM_HW) : LEN_W'(cnt_q);
  end

  // Placement of an incoming block: tag followed by payload, aligned at the
  // current fill count, with only the 1+n meaningful halfwords enabled.
  always_comb begin
    blk_ext  = {{(BUF_W - DATA_W - HW_W){1'b0}}, cprDataIn, HW_W'(tagIn)};
    blk_ins  = blk_ext << (HW_W * cnt_q);
    len_mask = (BUF_HW'(1) << (pop_n + CNT_ONE)) - BUF_HW'(1);
    hw_mask  = len_mask << cnt_q;
    for (int i = 0; i < BUF_HW; i++) begin
      data_mask[i*HW_W +: HW_W] = {HW_W{hw_mask[i]}};
    end
  end

  // Next-state logic for the buffer, fill count and flush state machine.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;

    // Draining and accepting never coincide: accepting needs cnt < NUM_HW in
    // ACCUM, where the output is idle.
    if (out_fire) begin
      buf_d = {{DATA_W{1'b0}}, buf_q[BUF_W-1:DATA_W]};
      cnt_d = (cnt_q >= CNT_FULL) ? (cnt_q - CNT_FULL) : '0;
    end else if (accept) begin
      buf_d = (buf_q & ~data_mask) | (blk_ins & data_mask);
      cnt_d = cnt_q + CNT_ONE + pop_n;
    end

    unique case (state_q)
      ST_ACCUM: if (flush) state_d = ST_FLUSH;
      ST_FLUSH: if (cnt_q == '0) state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the halfword buffer is cleared on reset because zero padding of a
    // partial word relies on every halfword above the fill count being zero.
    if (reset) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples the pre-edge values computed above.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

`ifdef PACKER_BLKCNT_EN
  logic [31:0] blk_q, blk_d;

  // Accepted-block counter, wraps naturally and clears once a flush completes.
  always_comb begin
    blk_d = blk_q;
    if (flushDone) begin
      blk_d = '0;
    end else if (accept) begin
      blk_d = blk_q + 32'd1;
    end
  end

  // Block counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q <= '0;
    end else begin
      blk_q <= blk_d;
    end
  end

  assign blkCount = blk_q;
`endif

endmodule

// File: tb/tb_cpr_stream_packer.sv
// Testbench for cpr_stream_packer: a directed vector table of the main
// scenarios, a hand-written back-pressure sequence, and a randomized run.
// Every cycle is compared against a queue-of-halfwords reference model.
module tb_cpr_stream_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         inValid;
  logic         inReady;
  logic [255:0] cprDataIn;
  logic [15:0]  tagIn;
  logic         flush;
  logic [255:0] dataOut;
  logic [4:0]   outLen;
  logic         outValid;
  logic         outReady;
  logic         flushDone;
`ifdef PACKER_BLKCNT_EN
  logic [31:0]  blk_count;
`endif

  always #5 clk = ~clk;

  cpr_stream_packer #(.HW_W(16), .NUM_HW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .inValid   (inValid),
    .inReady   (inReady),
    .cprDataIn (cprDataIn),
    .tagIn     (tagIn),
    .flush     (flush),
    .dataOut   (dataOut),
    .outLen    (outLen),
    .outValid  (outValid),
    .outReady  (outReady),
    .flushDone (flushDone)
`ifdef PACKER_BLKCNT_EN
    ,
    .blkCount  (blk_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the buffered stream as a plain halfword queue.
  logic [15:0] mq[$];
  bit          m_flushing = 1'b0;
  logic [31:0] m_blk = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every DUT output with what the model's queue implies.
  task automatic model_check();
    logic [255:0] ed;
    int sz;
    sz = mq.size();
    ed = '0;
    for (int i = 0; i < 16 && i < sz; i++) ed[16*i +: 16] = mq[i];
    check("model_dataOut", dataOut, ed);
    check("model_outLen", 256'(outLen), 256'((sz > 16) ? 16 : sz));
    check("model_outValid", 256'(outValid), 256'((sz >= 16) || (m_flushing && sz > 0)));
    check("model_inReady", 256'(inReady), 256'(!m_flushing && sz < 16));
    check("model_flushDone", 256'(flushDone), 256'(m_flushing && sz == 0));
`ifdef PACKER_BLKCNT_EN
    check("model_blkCount", 256'(blk_count), 256'(m_blk));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input bit rst_v, input bit in_v, input logic [15:0] tag,
                      input logic [255:0] pay, input bit fl, input bit ordy);
    int  sz;
    int  n;
    bit  m_valid, m_ready, m_done;
    reset     = rst_v;
    inValid   = in_v;
    tagIn     = tag;
    cprDataIn = pay;
    flush     = fl;
    outReady  = ordy;
    sz      = mq.size();
    m_valid = (sz >= 16) || (m_flushing && sz > 0);
    m_ready = !m_flushing && sz < 16;
    m_done  = m_flushing && sz == 0;
    @(posedge clk);
    #1;
    if (rst_v) begin
      mq.delete();
      m_flushing = 1'b0;
      m_blk      = '0;
    end else begin
      if (m_valid && ordy) begin
        for (int i = 0; i < 16 && mq.size() > 0; i++) void'(mq.pop_front());
      end
      if (m_done) begin
        m_flushing = 1'b0;
        m_blk      = '0;
      end else if (!m_flushing && fl) begin
        m_flushing = 1'b1;
      end else if (m_ready && in_v) begin
        n = $countones(tag);
        mq.push_back(tag);
        for (int k = 0; k < n; k++) mq.push_back(pay[16*k +: 16]);
        m_blk = m_blk + 32'd1;
      end
    end
    model_check();
  endtask

  typedef struct {
    bit           rst;
    bit           in_v;
    logic [15:0]  tag;
    logic [255:0] pay;
    bit           fl;
    bit           ordy;
    bit           e_valid;
    logic [4:0]   e_len;
    bit           e_ready;
    bit           e_done;
    logic [255:0] e_data;
  } vec_t;

  function automatic vec_t mk(bit rst, bit in_v, logic [15:0] tag, logic [255:0] pay,
                              bit fl, bit ordy, bit ev, logic [4:0] el, bit er,
                              bit ed, logic [255:0] edata);
    vec_t v;
    v.rst = rst; v.in_v = in_v; v.tag = tag; v.pay = pay; v.fl = fl; v.ordy = ordy;
    v.e_valid = ev; v.e_len = el; v.e_ready = er; v.e_done = ed; v.e_data = edata;
    return v;
  endfunction

  vec_t tbl[24];

  initial begin
    logic [255:0] p1, p3, p6a, pc, p20, junk;
    logic [255:0] w1, w3, w6a, w6c, w20, w4b;
    logic [15:0]  rtag;

    for (int k = 0; k < 16; k++) begin
      p1[16*k +: 16]  = 16'(k + 1);
      p3[16*k +: 16]  = 16'hEEEE;
      p6a[16*k +: 16] = 16'hDDDD;
      pc[16*k +: 16]  = 16'h7777;
      p20[16*k +: 16] = 16'h0100 + 16'(k);
    end
    p3[63:0]  = {16'hDEF1, 16'h9ABC, 16'h5678, 16'h1234};
    p6a[31:0] = {16'hBBBB, 16'hAAAA};
    pc[15:0]  = 16'hCCCC;

    w1  = {p1[239:0], 16'hFFFF};
    w3  = {176'b0, p3[63:0], 16'h800B};
    w6a = {208'b0, p6a[31:0], 16'h0003};
    w6c = {224'b0, pc[15:0], 16'h0001};
    w20 = {112'b0, p20[95:0], 16'h003F, w6c[31:0]};
    w4b = {208'b0, pc[15:0], 16'h0001, 16'h0010};

    //              rst in  tag       pay  fl ordy  val len rdy done data
    tbl[0]  = mk(0, 1, 16'hFFFF, p1,  0, 0,   1, 16, 0, 0, w1);
    tbl[1]  = mk(0, 0, 16'h0000, '0,  0, 1,   0, 1,  1, 0, 256'h10);
    tbl[2]  = mk(1, 0, 16'h0000, '0,  0, 1,   0, 0,  1, 0, '0);
    for (int k = 1; k <= 5; k++)
      tbl[2+k] = mk(0, 1, 16'h0000, p1, 0, 1, 0, 5'(k), 1, 0, '0);
    tbl[8]  = mk(0, 0, 16'h0000, '0,  1, 1,   1, 5,  0, 0, '0);
    tbl[9]  = mk(0, 0, 16'h0000, '0,  0, 1,   0, 0,  0, 1, '0);
    tbl[10] = mk(0, 0, 16'h0000, '0,  0, 1,   0, 0,  1, 0, '0);
    tbl[11] = mk(0, 1, 16'h800B, p3,  0, 1,   0, 5,  1, 0, w3);
    tbl[12] = mk(0, 0, 16'h0000, '0,  1, 1,   1, 5,  0, 0, w3);
    tbl[13] = mk(0, 0, 16'h0000, '0,  0, 1,   0, 0,  0, 1, '0);
    tbl[14] = mk(0, 0, 16'h0000, '0,  0, 1,   0, 0,  1, 0, '0);
    tbl[15] = mk(0, 1, 16'h0003, p6a, 0, 1,   0, 3,  1, 0, w6a);
    tbl[16] = mk(0, 1, 16'h0001, pc,  1, 1,   1, 3,  0, 0, w6a);
    tbl[17] = mk(0, 1, 16'h0001, pc,  0, 1,   0, 0,  0, 1, '0);
    tbl[18] = mk(0, 1, 16'h0001, pc,  0, 1,   0, 0,  1, 0, '0);
    tbl[19] = mk(0, 1, 16'h0001, pc,  0, 1,   0, 2,  1, 0, w6c);
    tbl[20] = mk(0, 1, 16'h003F, p20, 0, 1,   0, 9,  1, 0, w20);
    tbl[21] = mk(1, 0, 16'h0000, '0,  0, 1,   0, 0,  1, 0, '0);
    tbl[22] = mk(0, 0, 16'h0000, '0,  1, 1,   0, 0,  0, 1, '0);
    tbl[23] = mk(0, 0, 16'h0000, '0,  0, 1,   0, 0,  1, 0, '0);

    // Reset and its output state.
    step(1, 0, '0, '0, 0, 0);
    step(1, 0, '0, '0, 0, 0);
    check("reset_outValid", 256'(outValid), 256'(0));
    check("reset_dataOut", dataOut, '0);
    check("reset_inReady", 256'(inReady), 256'(1));

    // Directed vector table.
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].rst, tbl[i].in_v, tbl[i].tag, tbl[i].pay, tbl[i].fl, tbl[i].ordy);
      check($sformatf("tbl%0d_outValid", i), 256'(outValid), 256'(tbl[i].e_valid));
      check($sformatf("tbl%0d_outLen", i), 256'(outLen), 256'(tbl[i].e_len));
      check($sformatf("tbl%0d_inReady", i), 256'(inReady), 256'(tbl[i].e_ready));
      check($sformatf("tbl%0d_flushDone", i), 256'(flushDone), 256'(tbl[i].e_done));
      check($sformatf("tbl%0d_dataOut", i), dataOut, tbl[i].e_data);
    end

    // Back-pressure with cnt=17: output holds, input stalls, nothing is lost.
    step(0, 1, 16'hFFFF, p1, 0, 0);
    check("bp_fill_len", 256'(outLen), 256'(16));
    for (int c = 0; c < 10; c++) begin
      step(0, 1, 16'h0001, pc, 0, 0);
      check("bp_hold_data", dataOut, w1);
      check("bp_hold_inReady", 256'(inReady), 256'(0));
      check("bp_hold_outValid", 256'(outValid), 256'(1));
    end
    step(0, 1, 16'h0001, pc, 0, 1);
    check("bp_release_data", dataOut, 256'h10);
    check("bp_release_inReady", 256'(inReady), 256'(1));
    step(0, 1, 16'h0001, pc, 0, 1);
    check("bp_resume_len", 256'(outLen), 256'(3));
    check("bp_resume_data", dataOut, w4b);
    step(0, 0, '0, '0, 1, 1);
    step(0, 0, '0, '0, 0, 1);
    step(0, 0, '0, '0, 0, 1);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 8; k++) junk[32*k +: 32] = $urandom;
      case ($urandom_range(0, 3))
        0:       rtag = 16'h0000;
        1:       rtag = 16'hFFFF;
        default: rtag = 16'($urandom);
      endcase
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), rtag, junk,
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
